jam_cost_rom: RTL and testbench
===============================

Name: jam_cost_rom

Overview:
Responder side of the worker/job cost interface. Holds the 8x8 cost table and answers each W/J address with Cost. Captures the assignment engine's Valid/MinCost/MatchCount result and reports the cycle count for the run. Sits beside the assignment engine as its cost source and result sink, and is loaded serially by the host/test harness before a run.

Parameters:
COST_WIDTH, 7, width of one cost entry and of load_data/Cost
IDX_WIDTH, 3, width of W and J; table holds 2^(2*IDX_WIDTH) = 64 entries
CYC_WIDTH, 20, width of cycle_count (saturating)

Ports:
CLK  input  1  clock, all logic on rising edge
RST_N  input  1  synchronous active-low reset
load_valid  input  1  load beat present
load_data  input  COST_WIDTH  cost entry, row-major order: entry k is W=k[5:3], J=k[2:0]
load_ready  output  1  block accepts a load beat this cycle
restart  input  1  one-cycle pulse: discard table and result, return to LOAD
W  input  IDX_WIDTH  worker index from engine
J  input  IDX_WIDTH  job index from engine
Cost  output  COST_WIDTH  table[{W,J}]
table_ready  output  1  table fully loaded; engine may run
Valid  input  1  engine result strobe
MinCost  input  10  engine minimum total cost
MatchCount  input  4  engine count of minimum-cost assignments
result_valid  output  1  result captured
result_min_cost  output  10  captured MinCost
result_match_count  output  4  captured MatchCount
cycle_count  output  CYC_WIDTH  SERVE cycles from table_ready rising to Valid capture

Behaviour:
- Reset (RST_N=0 at an edge): state=LOAD, load address=0, table_ready=0, result_valid=0, result_min_cost=0, result_match_count=0, cycle_count=0. Table contents are not reset; Cost=0 in LOAD.
- States: LOAD, SERVE, DONE.
- LOAD: load_ready=1. A beat is accepted when load_valid&load_ready; it writes table[addr] and increments addr. On the accept with addr==63, go to SERVE and clear addr to 0. Gaps (load_valid=0) stall with no penalty.
- SERVE: load_ready=0 and load_valid is ignored. table_ready=1. Cost=table[{W,J}] combinational, same-cycle (the engine accumulates Cost in the cycle it drives W/J). cycle_count increments every SERVE cycle and saturates at all-ones. When Valid=1: capture MinCost/MatchCount, set result_valid=1, go to DONE. cycle_count is not incremented on the capture cycle.
- DONE: table_ready stays 1 and Cost is still served. Result and cycle_count are held. Further Valid pulses are ignored (first result wins).
- restart=1 in any state: at the next edge go to LOAD, addr=0, table_ready=0, result_valid=0, result regs=0, cycle_count=0. It takes priority over a simultaneous Valid or load accept.
- Valid in LOAD is ignored and nothing is captured.
- Reset mid-load: partial table is abandoned, and the next load starts at entry 0.
- Widths: addr is 6 bits and wraps only via the 63->SERVE transition. Result regs are the same width as the inputs, with no arithmetic.

Optional Feature:
Macro JAM_COST_REG_OUT_EN.
- Defined: Cost is registered, i.e. Cost at cycle n+1 = table[{W,J} sampled at n]. Cost=0 the cycle after reset or restart. For consumers with a one-cycle read protocol.
- Undefined: Cost is combinational, as described above, which is the configuration paired with the assignment engine.

Test Plan:
- Reset then load 64 beats with data=k mod 100 and load_valid toggling every other cycle -> load_ready=1 throughout LOAD; table_ready rises exactly after the 64th accept; load_ready=0 afterwards.
- In SERVE drive W=3,J=5 -> Cost=29 (entry 29) in the same cycle. Sweep all 64 addresses -> every Cost matches the loaded data.
- SERVE for 100 cycles, then Valid=1 with MinCost=10'd312, MatchCount=4'd2 -> next cycle result_valid=1, result_min_cost=312, result_match_count=2, cycle_count=100.
- In DONE, pulse Valid with MinCost=5 -> results unchanged (312/2). Pulse restart and Valid together -> state LOAD, result_valid=0, table_ready=0, cycle_count=0.
- Pulse RST_N low after 20 load beats, then reload 64 beats of value 7 -> every address reads Cost=7. Valid during LOAD -> result_valid stays 0.
- With JAM_COST_REG_OUT_EN: W=3,J=5 at cycle n -> Cost=29 at n+1 and not at n. Change W/J each cycle -> Cost trails by exactly one cycle.

Source files
------------

// File: rtl/jam_cost_rom_if.sv
// jam_cost_rom_if: worker/job cost interface between the assignment engine and the cost ROM.
//
// Signals:
//   W, J        worker/job index driven by the engine
//   Cost        cost entry returned for {W,J}
//   table_ready cost table fully loaded; the engine may run
//   Valid       engine result strobe
//   MinCost     engine minimum total cost
//   MatchCount  engine count of minimum-cost assignments
//
// Modports: master = assignment engine, slave = cost ROM.
interface jam_cost_rom_if #(
    parameter int unsigned COST_WIDTH = 7,
    parameter int unsigned IDX_WIDTH  = 3
);
    logic [IDX_WIDTH-1:0]  W;
    logic [IDX_WIDTH-1:0]  J;
    logic [COST_WIDTH-1:0] Cost;
    logic                  table_ready;
    logic                  Valid;
    logic [9:0]            MinCost;
    logic [3:0]            MatchCount;

    modport master (
        output W, J, Valid, MinCost, MatchCount,
        input  Cost, table_ready
    );

    modport slave (
        input  W, J, Valid, MinCost, MatchCount,
        output Cost, table_ready
    );
endinterface

// File: rtl/jam_cost_rom.sv
// jam_cost_rom: serially loaded 8x8 cost table serving the assignment engine, plus a sink that
// captures the engine's first result and the number of SERVE cycles it took.
//
// Ports:
//   CLK, RST_N          clock (rising edge) and synchronous active-low reset
//   load_valid/ready    serial load handshake, 64 beats in row-major order
//   load_data           cost entry for the current load beat
//   restart             one-cycle pulse: drop table and result, go back to loading
//   eng                 engine-facing cost/result interface (slave modport)
//   result_valid        first engine result captured
//   result_min_cost     captured MinCost
//   result_match_count  captured MatchCount
//   cycle_count         saturating SERVE cycle count up to the capture
//
// Build option: define JAM_COST_REG_OUT_EN to register Cost (one-cycle read latency);
// by default Cost is a same-cycle combinational read.
module jam_cost_rom #(
    parameter int unsigned COST_WIDTH = 7,
    parameter int unsigned IDX_WIDTH  = 3,
    parameter int unsigned CYC_WIDTH  = 20
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  load_valid,
    input  logic [COST_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  restart,
    jam_cost_rom_if.slave         eng,
    output logic                  result_valid,
    output logic [9:0]            result_min_cost,
    output logic [3:0]            result_match_count,
    output logic [CYC_WIDTH-1:0]  cycle_count
);
    localparam int unsigned AddrWidth = 2 * IDX_WIDTH;
    localparam int unsigned Depth     = 1 << AddrWidth;

    typedef enum logic [1:0] {StLoad, StServe, StDone} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   res_valid_q, res_valid_d;
    logic [9:0]             res_min_q, res_min_d;
    logic [3:0]             res_cnt_q, res_cnt_d;
    logic [CYC_WIDTH-1:0]   cyc_q, cyc_d;
    logic                   load_accept;
    logic [AddrWidth-1:0]   rd_idx;
    logic [COST_WIDTH-1:0]  mem [Depth];

    assign load_accept = (state_q == StLoad) && load_valid;
    assign rd_idx      = {eng.W, eng.J};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        res_valid_d = res_valid_q;
        res_min_d   = res_min_q;
        res_cnt_d   = res_cnt_q;
        cyc_d       = cyc_q;
        if (restart) begin
            state_d     = StLoad;
            addr_d      = '0;
            res_valid_d = 1'b0;
            res_min_d   = '0;
            res_cnt_d   = '0;
            cyc_d       = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (load_accept) begin
                        // Address wraps to 0 only on the final beat.
                        addr_d = addr_q + 1'b1;
                        if (addr_q == AddrWidth'(Depth - 1)) begin
                            state_d = StServe;
                        end
                    end
                end
                StServe: begin
                    if (eng.Valid) begin
                        res_valid_d = 1'b1;
                        res_min_d   = eng.MinCost;
                        res_cnt_d   = eng.MatchCount;
                        state_d     = StDone;
                    end else if (cyc_q != '1) begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                StDone: begin
                    // First result wins; everything is held until restart.
                end
                default: state_d = StLoad;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StLoad;
            addr_q      <= '0;
            res_valid_q <= 1'b0;
            res_min_q   <= '0;
            res_cnt_q   <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            res_valid_q <= res_valid_d;
            res_min_q   <= res_min_d;
            res_cnt_q   <= res_cnt_d;
            cyc_q       <= cyc_d;
        end
    end

    // Table storage is deliberately not reset; it is always fully rewritten before use.
    always_ff @(posedge CLK) begin
        if (RST_N && !restart && load_accept) begin
            mem[addr_q] <= load_data;
        end
    end

`ifdef JAM_COST_REG_OUT_EN
    logic [COST_WIDTH-1:0] cost_q, cost_d;

    always_comb begin
        cost_d = '0;
        if (!restart && (state_q != StLoad)) begin
            cost_d = mem[rd_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cost_q <= '0;
        end else begin
            cost_q <= cost_d;
        end
    end

    assign eng.Cost = cost_q;
`else
    // Same-cycle read: the engine accumulates Cost in the cycle it drives W/J.
    assign eng.Cost = (state_q == StLoad) ? '0 : mem[rd_idx];
`endif

    assign load_ready         = (state_q == StLoad);
    assign eng.table_ready    = (state_q != StLoad);
    assign result_valid       = res_valid_q;
    assign result_min_cost    = res_min_q;
    assign result_match_count = res_cnt_q;
    assign cycle_count        = cyc_q;
endmodule

// File: tb/tb_jam_cost_rom.sv
// tb_jam_cost_rom: directed self-checking bench for jam_cost_rom (either Cost build option).
`timescale 1ns/1ps
module tb_jam_cost_rom;
    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [6:0]  load_data;
    logic        load_ready;
    logic        restart;
    logic        result_valid;
    logic [9:0]  result_min_cost;
    logic [3:0]  result_match_count;
    logic [19:0] cycle_count;

    int checks;
    int failures;
    int serve_edges;

    jam_cost_rom_if #(.COST_WIDTH(7), .IDX_WIDTH(3)) eng_if ();

    jam_cost_rom #(.COST_WIDTH(7), .IDX_WIDTH(3), .CYC_WIDTH(20)) dut (
        .CLK                (clk),
        .RST_N              (rst_n),
        .load_valid         (load_valid),
        .load_data          (load_data),
        .load_ready         (load_ready),
        .restart            (restart),
        .eng                (eng_if.slave),
        .result_valid       (result_valid),
        .result_min_cost    (result_min_cost),
        .result_match_count (result_match_count),
        .cycle_count        (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until Cost reflects the W/J just driven; in the registered build that takes an edge.
    task automatic settle();
`ifdef JAM_COST_REG_OUT_EN
        tick();
        serve_edges++;
`else
        #1;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks += 6;
        if (load_ready !== 1'b1) begin
            failures++; $display("FAIL reset_load_ready got=%0d want=1", load_ready);
        end
        if (eng_if.table_ready !== 1'b0) begin
            failures++; $display("FAIL reset_table_ready got=%0d want=0", eng_if.table_ready);
        end
        if (result_valid !== 1'b0) begin
            failures++; $display("FAIL reset_result_valid got=%0d want=0", result_valid);
        end
        if (result_min_cost !== 10'd0 || result_match_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_result got=%0d/%0d want=0/0", result_min_cost, result_match_count);
        end
        if (cycle_count !== 20'd0) begin
            failures++; $display("FAIL reset_cycle_count got=%0d want=0", cycle_count);
        end
        if (eng_if.Cost !== 7'd0) begin
            failures++; $display("FAIL reset_cost got=%0d want=0", eng_if.Cost);
        end
    endtask

    // 64 beats of k mod 100 with load_valid high on every other cycle.
    task automatic test_load();
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < 64 && cyc < 200) begin
            load_valid = (cyc % 2 == 0);
            load_data  = 7'(k % 100);
            #1;
            checks++;
            if (load_ready !== 1'b1) begin
                failures++; $display("FAIL load_ready_in_load beat=%0d got=%0d want=1", k, load_ready);
            end
            tick();
            if (load_valid) k++;
            cyc++;
            if (k < 64) begin
                checks++;
                if (eng_if.table_ready !== 1'b0) begin
                    failures++; $display("FAIL early_table_ready beat=%0d got=1 want=0", k);
                end
            end
        end
        load_valid = 1'b0;
        checks += 3;
        if (k !== 64) begin
            failures++; $display("FAIL load_beats got=%0d want=64", k);
        end
        if (eng_if.table_ready !== 1'b1) begin
            failures++; $display("FAIL table_ready_after_load got=%0d want=1", eng_if.table_ready);
        end
        if (load_ready !== 1'b0) begin
            failures++; $display("FAIL load_ready_after_load got=%0d want=0", load_ready);
        end
    endtask

    task automatic test_cost_read();
        logic [5:0] a6;
        eng_if.W = 3'd3;
        eng_if.J = 3'd5;
        settle();
        checks++;
        if (eng_if.Cost !== 7'd29) begin
            failures++; $display("FAIL cost_w3_j5 got=%0d want=29", eng_if.Cost);
        end
        // Load beats offered during SERVE must be ignored.
        load_valid = 1'b1;
        load_data  = 7'd127;
        for (int a = 0; a < 64; a++) begin
            a6 = 6'(a);
            {eng_if.W, eng_if.J} = a6;
`ifdef JAM_COST_REG_OUT_EN
            tick();
            serve_edges++;
`else
            #1;
`endif
            checks += 2;
            if (eng_if.Cost !== 7'(a % 100)) begin
                failures++; $display("FAIL sweep addr=%0d got=%0d want=%0d", a, eng_if.Cost, a % 100);
            end
            if (load_ready !== 1'b0) begin
                failures++; $display("FAIL load_ready_in_serve got=%0d want=0", load_ready);
            end
`ifndef JAM_COST_REG_OUT_EN
            tick();
            serve_edges++;
`endif
        end
        load_valid = 1'b0;
        eng_if.W = 3'd0;
        eng_if.J = 3'd0;
        settle();
        checks++;
        if (eng_if.Cost !== 7'd0) begin
            failures++; $display("FAIL entry0_after_serve_load got=%0d want=0", eng_if.Cost);
        end
    endtask

`ifdef JAM_COST_REG_OUT_EN
    task automatic test_reg_out();
        logic [5:0] seq [4];
        seq[0] = 6'd29; seq[1] = 6'd7; seq[2] = 6'd63; seq[3] = 6'd40;
        eng_if.W = 3'd3;
        eng_if.J = 3'd5;
        #1;
        checks++;
        if (eng_if.Cost === 7'd29) begin
            failures++; $display("FAIL reg_out_same_cycle got=29 want=0");
        end
        tick();
        serve_edges++;
        checks++;
        if (eng_if.Cost !== 7'd29) begin
            failures++; $display("FAIL reg_out_next_cycle got=%0d want=29", eng_if.Cost);
        end
        for (int i = 1; i < 4; i++) begin
            {eng_if.W, eng_if.J} = seq[i];
            #1;
            checks++;
            if (eng_if.Cost !== 7'(seq[i-1] % 100)) begin
                failures++;
                $display("FAIL reg_out_trail i=%0d got=%0d want=%0d", i, eng_if.Cost, seq[i-1] % 100);
            end
            tick();
            serve_edges++;
        end
    endtask
`endif

    task automatic test_result();
        while (serve_edges < 100) begin
            tick();
            serve_edges++;
        end
        eng_if.Valid      = 1'b1;
        eng_if.MinCost    = 10'd312;
        eng_if.MatchCount = 4'd2;
        tick();
        eng_if.Valid = 1'b0;
        checks += 4;
        if (result_valid !== 1'b1) begin
            failures++; $display("FAIL result_valid got=%0d want=1", result_valid);
        end
        if (result_min_cost !== 10'd312) begin
            failures++; $display("FAIL result_min_cost got=%0d want=312", result_min_cost);
        end
        if (result_match_count !== 4'd2) begin
            failures++; $display("FAIL result_match_count got=%0d want=2", result_match_count);
        end
        if (cycle_count !== 20'd100) begin
            failures++; $display("FAIL cycle_count got=%0d want=100", cycle_count);
        end
    endtask

    task automatic test_done();
        eng_if.Valid      = 1'b1;
        eng_if.MinCost    = 10'd5;
        eng_if.MatchCount = 4'd7;
        tick();
        eng_if.Valid = 1'b0;
        tick();
        tick();
        eng_if.W = 3'd3;
        eng_if.J = 3'd5;
        settle();
        checks += 4;
        if (result_min_cost !== 10'd312 || result_match_count !== 4'd2) begin
            failures++;
            $display("FAIL done_hold_result got=%0d/%0d want=312/2", result_min_cost, result_match_count);
        end
        if (cycle_count !== 20'd100) begin
            failures++; $display("FAIL done_hold_cycle_count got=%0d want=100", cycle_count);
        end
        if (eng_if.table_ready !== 1'b1) begin
            failures++; $display("FAIL done_table_ready got=%0d want=1", eng_if.table_ready);
        end
        if (eng_if.Cost !== 7'd29) begin
            failures++; $display("FAIL done_cost got=%0d want=29", eng_if.Cost);
        end
    endtask

    task automatic test_restart();
        restart           = 1'b1;
        eng_if.Valid      = 1'b1;
        eng_if.MinCost    = 10'd9;
        eng_if.MatchCount = 4'd1;
        tick();
        restart      = 1'b0;
        eng_if.Valid = 1'b0;
        checks += 5;
        if (result_valid !== 1'b0) begin
            failures++; $display("FAIL restart_result_valid got=%0d want=0", result_valid);
        end
        if (result_min_cost !== 10'd0 || result_match_count !== 4'd0) begin
            failures++;
            $display("FAIL restart_result got=%0d/%0d want=0/0", result_min_cost, result_match_count);
        end
        if (eng_if.table_ready !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_state table_ready=%0d load_ready=%0d want=0/1",
                     eng_if.table_ready, load_ready);
        end
        if (cycle_count !== 20'd0) begin
            failures++; $display("FAIL restart_cycle_count got=%0d want=0", cycle_count);
        end
        if (eng_if.Cost !== 7'd0) begin
            failures++; $display("FAIL restart_cost got=%0d want=0", eng_if.Cost);
        end
    endtask

    // Abandon a partial load with reset, reload all sevens while Valid is asserted in LOAD.
    task automatic test_reset_midload();
        int k;
        load_valid = 1'b1;
        load_data  = 7'd50;
        repeat (20) tick();
        load_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load_valid        = 1'b1;
        load_data         = 7'd7;
        eng_if.Valid      = 1'b1;
        eng_if.MinCost    = 10'd99;
        eng_if.MatchCount = 4'd3;
        k = 0;
        while (k < 64) begin
            tick();
            k++;
            checks++;
            if (result_valid !== 1'b0) begin
                failures++; $display("FAIL valid_in_load beat=%0d got=1 want=0", k);
            end
            if (k < 64) begin
                checks++;
                if (eng_if.table_ready !== 1'b0) begin
                    failures++; $display("FAIL midload_early_ready beat=%0d got=1 want=0", k);
                end
            end
        end
        load_valid   = 1'b0;
        eng_if.Valid = 1'b0;
        checks += 2;
        if (eng_if.table_ready !== 1'b1) begin
            failures++; $display("FAIL reload_table_ready got=%0d want=1", eng_if.table_ready);
        end
        if (result_valid !== 1'b0) begin
            failures++; $display("FAIL reload_result_valid got=%0d want=0", result_valid);
        end
        for (int a = 0; a < 64; a++) begin
            {eng_if.W, eng_if.J} = 6'(a);
            settle();
            checks++;
            if (eng_if.Cost !== 7'd7) begin
                failures++; $display("FAIL reload_sweep addr=%0d got=%0d want=7", a, eng_if.Cost);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks            = 0;
        failures          = 0;
        serve_edges       = 0;
        rst_n             = 1'b0;
        load_valid        = 1'b0;
        load_data         = '0;
        restart           = 1'b0;
        eng_if.W          = '0;
        eng_if.J          = '0;
        eng_if.Valid      = 1'b0;
        eng_if.MinCost    = '0;
        eng_if.MatchCount = '0;
        test_reset();
        test_load();
        test_cost_read();
`ifdef JAM_COST_REG_OUT_EN
        test_reg_out();
`endif
        test_result();
        test_done();
        test_restart();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
